fifo_uart_drain: RTL and testbench

Downstream consumer of the design's synchronous FIFO. Pops one word whenever the FIFO is non-empty and the block is enabled, then serializes it onto a single UART-style line: start bit, DATA_WIDTH data bits LSB first, one stop bit. Provides busy, per-frame done pulse and a frame counter so the class-based environment's monitor/scoreboard can check drained data against generated transactions.

---
 rtl/fifo_uart_drain_if.sv | 10 +
 rtl/fifo_uart_drain.sv | 80 ++++++++
 tb/tb_fifo_uart_drain.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/fifo_uart_drain_if.sv
// fifo_uart_drain_if: read-side handshake between a synchronous FIFO and its drain.
interface fifo_uart_drain_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  fifo_empty;
    logic                  fifo_rd;
    logic [DATA_WIDTH-1:0] fifo_data;
    modport master(input fifo_empty, fifo_data, output fifo_rd);
    modport slave(output fifo_empty, fifo_data, input fifo_rd);
endinterface

// File: rtl/fifo_uart_drain.sv
// fifo_uart_drain: pops FIFO words and serializes each as start, LSB-first data, stop.
module fifo_uart_drain #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                   clock,
    input  logic                   rst,
    fifo_uart_drain_if.master      bus,
    input  logic                   enable,
    output logic                   tx,
    output logic                   busy,
    output logic                   frame_done,
    output logic [15:0]            frames_sent
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] POP   = 3'd1;
    localparam logic [2:0] LOAD  = 3'd2;
    localparam logic [2:0] START = 3'd3;
    localparam logic [2:0] DATA  = 3'd4;
    localparam logic [2:0] STOP  = 3'd5;
    localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;

    logic [2:0]            state;
    logic [CW-1:0]         cyc;
    logic [BW-1:0]         bit_idx;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  cyc_last;
    logic                  bit_last;

    always_comb begin
        cyc_last    = cyc == CW'(CLKS_PER_BIT - 1);
        bit_last    = bit_idx == BW'(DATA_WIDTH - 1);
        tx          = (state == START) ? 1'b0 : (state == DATA) ? shreg[0] : 1'b1;
        busy        = state != IDLE;
        bus.fifo_rd = state == POP;
        frame_done  = (state == STOP) && cyc_last;
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state       <= IDLE;
            cyc         <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            frames_sent <= '0;
        end else begin
            case (state)
                IDLE: state <= (enable && !bus.fifo_empty) ? POP : IDLE;
                POP:  state <= LOAD;
                LOAD: begin
                    shreg <= bus.fifo_data;
                    cyc   <= '0;
                    state <= START;
                end
                START: begin
                    cyc     <= cyc_last ? '0 : cyc + 1'b1;
                    bit_idx <= '0;
                    state   <= cyc_last ? DATA : START;
                end
                DATA: begin
                    cyc <= cyc_last ? '0 : cyc + 1'b1;
                    if (cyc_last) begin
                        shreg   <= shreg >> 1;
                        bit_idx <= bit_idx + 1'b1;
                        state   <= bit_last ? STOP : DATA;
                    end
                end
                STOP: begin
                    cyc <= cyc_last ? '0 : cyc + 1'b1;
                    if (cyc_last) begin
                        frames_sent <= frames_sent + 16'd1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_uart_drain.sv
// tb_fifo_uart_drain: FIFO model plus line receiver; table of single frames and directed corner sequences.
module tb_fifo_uart_drain;
    typedef struct {
        logic [7:0] data;
        logic [9:0] line;
    } vec_t;

    logic        clock = 1'b0;
    logic        rst, enable, tx, busy, frame_done;
    logic [15:0] frames_sent;
    logic        push_en, clr;
    logic [7:0]  push_data;
    logic [7:0]  q[$];
    logic [9:0]  rx_q[$];
    logic [9:0]  rx_bits;
    logic        prev_empty;
    int          rx_cyc = -1;
    int          cyc_n = 0;
    int          rd_cnt = 0;
    int          rd_times[$];
    int          total = 0;
    int          bad = 0;

    fifo_uart_drain_if #(.DATA_WIDTH(8)) bus ();

    fifo_uart_drain #(.DATA_WIDTH(8), .CLKS_PER_BIT(4)) dut (
        .clock(clock), .rst(rst), .bus(bus), .enable(enable), .tx(tx),
        .busy(busy), .frame_done(frame_done), .frames_sent(frames_sent)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc_n++;

    // FIFO data appears the cycle after fifo_rd is sampled high
    always @(posedge clock) begin
        if (clr) q.delete();
        else begin
            if (bus.fifo_rd) bus.fifo_data <= (q.size() > 0) ? q.pop_front() : 8'hxx;
            if (push_en) q.push_back(push_data);
        end
        bus.fifo_empty <= q.size() == 0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    // Receiver samples the second cycle of each 4-cycle line bit
    always @(negedge clock) begin
        if (rst) rx_cyc = -1;
        else begin
            if (rx_cyc < 0) begin
                if (tx === 1'b0) rx_cyc = 0;
            end else rx_cyc++;
            if (rx_cyc >= 0 && rx_cyc % 4 == 1) rx_bits[rx_cyc/4] = tx;
            if (rx_cyc == 39) begin
                chk("done_on_last_stop_cycle", {31'd0, frame_done}, 1);
                rx_q.push_back(rx_bits);
                rx_cyc = -1;
            end
        end
        if (bus.fifo_rd === 1'b1) begin
            rd_cnt++;
            rd_times.push_back(cyc_n);
            chk("rd_after_nonempty", {31'd0, prev_empty}, 0);
        end
        prev_empty = bus.fifo_empty;
    end

    task automatic push(input logic [7:0] d);
        push_en   = 1'b1;
        push_data = d;
        @(negedge clock);
        push_en = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int i;
        for (i = 0; i < 400; i++) begin
            @(negedge clock);
            if (frame_done === 1'b1) break;
        end
        chk({name, "_timeout"}, {31'd0, i < 400}, 1);
        @(negedge clock);
    endtask

    task automatic check_frame(input string name, input logic [9:0] exp);
        logic [9:0] got;
        got = 'x;
        if (rx_q.size() > 0) got = rx_q.pop_front();
        chk(name, {22'd0, got}, {22'd0, exp});
    endtask

    task automatic check_idle_outputs(input string name, input logic [15:0] frames);
        chk({name, "_tx"}, {31'd0, tx}, 1);
        chk({name, "_rd"}, {31'd0, bus.fifo_rd}, 0);
        chk({name, "_busy"}, {31'd0, busy}, 0);
        chk({name, "_done"}, {31'd0, frame_done}, 0);
        chk({name, "_frames"}, {16'd0, frames_sent}, {16'd0, frames});
    endtask

    initial begin
        vec_t tv[7];
        int   r0, lows, k;
        tv[0] = '{8'hA5, 10'h34A};
        tv[1] = '{8'h01, 10'h202};
        tv[2] = '{8'h80, 10'h300};
        tv[3] = '{8'hFF, 10'h3FE};
        tv[4] = '{8'h3C, 10'h278};
        tv[5] = '{8'h00, 10'h200};
        tv[6] = '{8'h5A, 10'h2B4};
        rst = 1'b1; enable = 1'b1; clr = 1'b0; push_en = 1'b0; push_data = '0;
        @(negedge clock);
        push(8'h11);
        repeat (2) begin
            @(negedge clock);
            check_idle_outputs("reset", 16'd0);
        end
        enable = 1'b0; clr = 1'b1;
        @(negedge clock);
        clr = 1'b0; rst = 1'b0;
        @(negedge clock);
        enable = 1'b1;

        for (int i = 0; i < 7; i++) begin
            r0 = rd_cnt;
            push(tv[i].data);
            wait_done("vec");
            check_frame("vec_line", tv[i].line);
            chk("vec_rd_pulses", rd_cnt - r0, 1);
            chk("vec_frames", {16'd0, frames_sent}, i + 1);
            chk("vec_idle_busy", {31'd0, busy}, 0);
            chk("vec_idle_tx", {31'd0, tx}, 1);
        end

        enable = 1'b0;
        push(8'h01); push(8'h80); push(8'hFF);
        rd_times.delete();
        enable = 1'b1;
        repeat (3) wait_done("b2b");
        check_frame("b2b_0", 10'h202);
        check_frame("b2b_1", 10'h300);
        check_frame("b2b_2", 10'h3FE);
        chk("b2b_rd_count", rd_times.size(), 3);
        if (rd_times.size() == 3) begin
            chk("b2b_period_01", rd_times[1] - rd_times[0], 43);
            chk("b2b_period_12", rd_times[2] - rd_times[1], 43);
        end
        chk("b2b_frames", {16'd0, frames_sent}, 10);
        chk("b2b_tx", {31'd0, tx}, 1);
        chk("b2b_busy", {31'd0, busy}, 0);

        enable = 1'b0;
        push(8'h12); push(8'h34);
        r0 = rd_cnt;
        enable = 1'b1;
        for (k = 0; k < 200 && rx_cyc < 10; k++) @(negedge clock);
        enable = 1'b0;
        wait_done("gate_first");
        repeat (60) @(negedge clock);
        chk("gate_held_rd", rd_cnt - r0, 1);
        chk("gate_held_busy", {31'd0, busy}, 0);
        enable = 1'b1;
        wait_done("gate_second");
        chk("gate_rd", rd_cnt - r0, 2);
        check_frame("gate_0", 10'h224);
        check_frame("gate_1", 10'h268);
        chk("gate_frames", {16'd0, frames_sent}, 12);

        enable = 1'b0;
        push(8'h3C); push(8'h77);
        enable = 1'b1;
        for (k = 0; k < 200 && rx_cyc < 17; k++) @(negedge clock);
        rst = 1'b1;
        @(negedge clock);
        check_idle_outputs("midreset", 16'd0);
        rst = 1'b0;
        wait_done("midreset_next");
        check_frame("midreset_next_line", 10'h2EE);
        chk("midreset_no_resend", rx_q.size(), 0);
        chk("midreset_frames", {16'd0, frames_sent}, 1);

        r0 = rd_cnt;
        lows = 0;
        repeat (100) begin
            @(negedge clock);
            if (tx !== 1'b1) lows++;
        end
        chk("empty_no_rd", rd_cnt - r0, 0);
        chk("empty_tx_high", lows, 0);
        chk("empty_busy", {31'd0, busy}, 0);

        force dut.frames_sent = 16'hFFFF;
        @(negedge clock);
        release dut.frames_sent;
        @(negedge clock);
        chk("wrap_preload", {16'd0, frames_sent}, 32'h0000FFFF);
        push(8'h42);
        wait_done("wrap");
        check_frame("wrap_line", 10'h284);
        chk("wrap_frames", {16'd0, frames_sent}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
